// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_stage_pkg
// Brief   : Shared types and defaults for the pipeline memory stage.
// Revision: 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam int DEF_DATA_W      = 32;
    localparam int DEF_REG_ADDR_W  = 5;
    localparam int DEF_ADDR_OFFSET = 1024;

endpackage
`default_nettype wire

// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
// Module  : mem_stage_if
// Brief   : req/ack bus between the memory stage and the data-memory controller.
// Revision: 1.0 - initial release
// ============================================================================
interface mem_stage_if #(
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_reg
// Brief   : Pipeline register with async reset, load enable and sync clear.
// Revision: 1.0 - initial release
// ============================================================================
module pipe_reg #(
    parameter int WIDTH = 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_en,
    input  wire logic             i_clr,
    input  wire logic [WIDTH-1:0] i_d,
    output logic      [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_q;

    // Clear wins over enable so a bubble can be forced regardless of stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;
endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module  : mem_stage
// Brief   : MEM stage: EX/MEM latch, req/ack data-memory access with upstream
//           freeze, MEM/WB register and forwarding outputs.
//           Optional macro MEM_ALIGN_CHECK_EN adds misaligned-access trapping.
// Revision: 1.0 - initial release
// ============================================================================
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
    parameter int ADDR_OFFSET = DEF_ADDR_OFFSET
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  wb_en_in,
    input  wire logic                  mem_read_in,
    input  wire logic                  mem_write_in,
    input  wire logic [DATA_W-1:0]     alu_result_in,
    input  wire logic [DATA_W-1:0]     st_val_in,
    input  wire logic [REG_ADDR_W-1:0] dest_in,
    mem_stage_if.master                mem_bus,
    output logic                       freeze,
    output logic [DATA_W-1:0]          fwd_data,
    output logic [REG_ADDR_W-1:0]      fwd_dest,
    output logic                       fwd_wb_en,
    output logic                       wb_en_out,
    output logic                       mem_read_out,
    output logic [REG_ADDR_W-1:0]      dest_out,
    output logic [DATA_W-1:0]          alu_result_out,
    output logic [DATA_W-1:0]          mem_data_out
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic                       misalign_err
`endif
);
    localparam int EXM_W = 3 + 2*DATA_W + REG_ADDR_W;
    localparam int MWB_W = 2 + REG_ADDR_W + 2*DATA_W;
    localparam logic [DATA_W-1:0] c_ADDR_OFF = DATA_W'(ADDR_OFFSET);

    logic [EXM_W-1:0]      w_exm_d;
    logic [EXM_W-1:0]      w_exm_q;
    logic [MWB_W-1:0]      w_mwb_d;
    logic [MWB_W-1:0]      w_mwb_q;

    logic                  r_ex_wb_en;
    logic                  r_ex_mem_read;
    logic                  r_ex_mem_write;
    logic [DATA_W-1:0]     r_ex_alu;
    logic [DATA_W-1:0]     r_ex_st_val;
    logic [REG_ADDR_W-1:0] r_ex_dest;

    state_t                r_state;
    state_t                w_next;
    logic                  w_is_mem;
    logic                  w_misalign;
    logic                  w_req;
    logic                  w_freeze;
    logic                  w_bubble;
    logic [DATA_W-1:0]     w_addr;
    logic                  w_wb_en_eff;
    logic                  w_rd_eff;
    logic [DATA_W-1:0]     w_mem_data;

    // ------------------------------------------------------------------ EX/MEM
    assign w_exm_d = {wb_en_in, mem_read_in, mem_write_in,
                      alu_result_in, st_val_in, dest_in};

    pipe_reg #(.WIDTH(EXM_W)) u_ex_mem (
        .clk   (clk),
        .rst   (rst),
        .i_en  (~w_freeze),
        .i_clr (1'b0),
        .i_d   (w_exm_d),
        .o_q   (w_exm_q)
    );

    assign {r_ex_wb_en, r_ex_mem_read, r_ex_mem_write,
            r_ex_alu, r_ex_st_val, r_ex_dest} = w_exm_q;

    assign w_is_mem = r_ex_mem_read | r_ex_mem_write;
    assign w_addr   = r_ex_alu - c_ADDR_OFF;

`ifdef MEM_ALIGN_CHECK_EN
    logic r_misalign_err;

    assign w_misalign = w_is_mem & (w_addr[1:0] != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_misalign_err <= 1'b0;
        end else if ((r_state == IDLE) && w_misalign) begin
            r_misalign_err <= 1'b1;
        end
    end

    assign misalign_err = r_misalign_err;
`else
    assign w_misalign = 1'b0;
`endif

    // --------------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_req    = 1'b0;
        w_freeze = 1'b0;
        w_bubble = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_is_mem) begin
                    w_bubble = 1'b1;
                    if (!w_misalign) begin
                        w_req    = 1'b1;
                        w_freeze = 1'b1;
                        w_next   = WAIT;
                    end
                end
            end
            WAIT: begin
                w_req = 1'b1;
                // The ack cycle releases the pipe so the next op enters with no gap.
                if (mem_bus.mem_ack) begin
                    w_next = IDLE;
                end else begin
                    w_freeze = 1'b1;
                    w_bubble = 1'b1;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign mem_bus.mem_req   = w_req;
    assign mem_bus.mem_we    = w_req & r_ex_mem_write;
    assign mem_bus.mem_addr  = w_addr;
    assign mem_bus.mem_wdata = r_ex_st_val;
    assign freeze            = w_freeze;

    // ------------------------------------------------------------------ MEM/WB
    // A read+write op is a store: no writeback and no load data.
    assign w_wb_en_eff = r_ex_wb_en & ~r_ex_mem_write;
    assign w_rd_eff    = r_ex_mem_read & ~r_ex_mem_write;
    assign w_mem_data  = ((r_state == WAIT) && !r_ex_mem_write) ? mem_bus.mem_rdata
                                                                : '0;

    assign w_mwb_d = {w_wb_en_eff, w_rd_eff, r_ex_dest, r_ex_alu, w_mem_data};

    pipe_reg #(.WIDTH(MWB_W)) u_mem_wb (
        .clk   (clk),
        .rst   (rst),
        .i_en  (1'b1),
        .i_clr (w_bubble),
        .i_d   (w_mwb_d),
        .o_q   (w_mwb_q)
    );

    assign {wb_en_out, mem_read_out, dest_out, alu_result_out, mem_data_out} = w_mwb_q;

    assign fwd_data  = r_ex_alu;
    assign fwd_dest  = r_ex_dest;
    assign fwd_wb_en = r_ex_wb_en;
endmodule
`default_nettype wire
